filter_sample_feeder: RTL
=========================

Name: filter_sample_feeder

Overview:
Upstream-facing sample source for the time-multiplexed shift-add FIR filter. It accepts samples over a valid/ready handshake and buffers them in a small FIFO. It drives the filter's 18-bit sample input, holding each sample stable for one full filter frame. It runs its own frame counter, which is cycle-identical to the filter's, so each sample is updated exactly on the filter's load edge.

Parameters:
DATA_W, 18, sample width (signed two's complement); must equal the filter input width
DEPTH, 4, FIFO depth in samples; power of two, minimum 2
CNT_W, 7, frame counter width; matches the filter's i_fop_fin width
UCNT_W, 8, underrun counter width

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_fop_fin  in  CNT_W  frame terminal count; frame period = i_fop_fin+1 cycles; same signal as fed to the filter
i_valid  in  1  upstream sample valid
i_data  in  DATA_W  upstream sample, signed
o_ready  out  1  feeder can accept a sample this cycle
o_filter  out  DATA_W  sample to the filter's i_filter, registered
o_frame  out  1  high in the cycle whose closing edge is the filter load edge (cnt == i_fop_fin)
o_underrun  out  1  one-cycle pulse: FIFO was empty at a frame edge
o_underrun_cnt  out  UCNT_W  saturating underrun count
o_level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (i_rst high at an edge): cnt <= i_fop_fin; FIFO flushed (o_level=0); o_filter=0; o_underrun=0; o_underrun_cnt=0. Reset has priority over all other events, including mid-frame.
- o_ready = !full && !i_rst, combinational. Push occurs when i_valid && o_ready. No push into a full FIFO, and no full-FIFO bypass: a pop and a push-attempt in the same cycle while full leaves ready low for that cycle.
- Frame counter: if cnt == i_fop_fin then cnt <= 0, else cnt <= cnt+1 (wraps mod 2^CNT_W). This is identical to the filter's counter, so alignment holds when both are reset on the same edge.
- o_frame = (cnt == i_fop_fin), combinational. It is high in the first cycle after reset release.
- Frame edge (o_frame high, not in reset):
  - FIFO non-empty: o_filter <= head; pop.
  - FIFO empty: o_filter <= 0; o_underrun <= 1 for one cycle; o_underrun_cnt increments, saturating at 2^UCNT_W-1.
  - No empty bypass: a push on the same edge as a pop of an empty FIFO still counts as an underrun, and the pushed sample stays queued.
- At a frame edge the filter latches the old o_filter while the feeder loads the next sample. Every presented sample is therefore consumed by the filter one frame later.
- Latency: a sample pushed into an empty FIFO reaches o_filter at the next frame edge and is consumed at the following one.
- Simultaneous push and pop: o_level is unchanged.
- Outside frame edges, o_filter holds its value.
- i_fop_fin changed mid-frame: the equality compare uses the new value. If cnt already exceeds it, the counter runs to wrap, exactly as the filter does. Values below 15 are outside the filter's operating range; the feeder still behaves mechanically as specified.
- All state updates occur on the i_clk rising edge only. Data is not modified (no rounding or saturation).

Decomposition:
- Shared package filter_pkg: DATA_W, CNT_W, and the minimum-frame constant FOP_FIN_MIN=15 (also used by the filter).
- One sub-module: sync_fifo (DEPTH x DATA_W, synchronous reset, push/pop/full/empty/level).
- Frame counter, output register and underrun logic stay in filter_sample_feeder.

Test Plan:
1. i_fop_fin=15; release reset, hold i_valid low for 1 cycle -> o_frame=1 in cycle 0, o_underrun pulse in cycle 1, o_underrun_cnt=1, o_filter=0.
2. Push 100, -200, 131071 back-to-back after cycle 1 -> o_filter=100 from edge 16, -200 from edge 32, 131071 from edge 48; each value held 16 cycles.
3. DEPTH=4; hold i_valid high with 5 samples -> 4 accepted, o_ready=0, o_level=4; after the next frame edge o_level=3 and o_ready=1, so the 5th is accepted.
4. At o_level=2, push on a frame edge -> o_level stays 2, head pops correctly, no underrun.
5. Starve for 300 frames -> o_underrun_cnt saturates at 255; o_filter=0 throughout.
6. Assert i_rst mid-frame with o_level=3, then change i_fop_fin to 31 -> next cycle o_level=0, o_filter=0, o_frame=1; the following frame edges are 32 cycles apart and match a reference counter.

Source files
------------

// File: rtl/filter_pkg.sv
// Constants shared between the shift-add FIR filter and its sample feeder.
package filter_pkg;
    localparam int FILT_DATA_W  = 18;
    localparam int FILT_CNT_W   = 7;
    localparam int FOP_FIN_MIN  = 15;
    localparam int FEED_DEPTH   = 4;
    localparam int FEED_UCNT_W  = 8;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers; storage is not reset, only control.
module sync_fifo
    import filter_pkg::*;
#(
    parameter int DEPTH = FEED_DEPTH,
    parameter int W     = FILT_DATA_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_push,
    input  logic                i_pop,
    input  logic signed [W-1:0] i_data,
    output logic signed [W-1:0] o_head,
    output logic                o_full,
    output logic                o_empty,
    output logic [LW-1:0]       o_level
);

    logic signed [W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_q, wr_d;
    logic [AW-1:0]       rd_q, rd_d;
    logic [LW-1:0]       level_q, level_d;
    logic                push_ok;
    logic                pop_ok;

    assign o_full  = (level_q == LW'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_head  = mem_q[rd_q];
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (push_ok) wr_d = wr_q + AW'(1);
        if (pop_ok)  rd_d = rd_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_q] <= i_data;
    end

endmodule

// File: rtl/filter_sample_feeder.sv
// Buffers upstream samples and presents one per filter frame, aligned to the
// filter's load edge by a frame counter that mirrors the filter's own.
module filter_sample_feeder
    import filter_pkg::*;
#(
    parameter int DATA_W = FILT_DATA_W,
    parameter int DEPTH  = FEED_DEPTH,
    parameter int CNT_W  = FILT_CNT_W,
    parameter int UCNT_W = FEED_UCNT_W,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [CNT_W-1:0]         i_fop_fin,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data,
    output logic                     o_ready,
    output logic signed [DATA_W-1:0] o_filter,
    output logic                     o_frame,
    output logic                     o_underrun,
    output logic [UCNT_W-1:0]        o_underrun_cnt,
    output logic [LW-1:0]            o_level
);

    function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
        return (v == '1) ? v : v + UCNT_W'(1);
    endfunction

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [DATA_W-1:0] filter_q, filter_d;
    logic                     underrun_q, underrun_d;
    logic [UCNT_W-1:0]        ucnt_q, ucnt_d;

    logic signed [DATA_W-1:0] head;
    logic                     full;
    logic                     empty;
    logic                     push;
    logic                     pop;

    assign o_frame        = (cnt_q == i_fop_fin);
    assign o_ready        = !full && !i_rst;
    assign push           = i_valid && o_ready;
    assign pop            = o_frame && !empty && !i_rst;
    assign o_filter       = filter_q;
    assign o_underrun     = underrun_q;
    assign o_underrun_cnt = ucnt_q;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (i_data),
        .o_head  (head),
        .o_full  (full),
        .o_empty (empty),
        .o_level (o_level)
    );

    // An empty FIFO at the frame edge presents zero; a same-edge push is not bypassed.
    always_comb begin
        cnt_d      = o_frame ? '0 : cnt_q + CNT_W'(1);
        filter_d   = filter_q;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;
        if (o_frame) begin
            if (!empty) begin
                filter_d = head;
            end else begin
                filter_d   = '0;
                underrun_d = 1'b1;
                ucnt_d     = sat_inc(ucnt_q);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q      <= i_fop_fin;
            filter_q   <= '0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            filter_q   <= filter_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

endmodule
